sqrt_arbiter: RTL

//  Shares one sequential square-root core (8-bit x -> 4-bit r, driven through core_enb_o/core_busy_i)

---
 rtl/sqrt_pkg.sv | 19 +
 rtl/sqrt_rr_arb.sv | 50 +++++
 rtl/sqrt_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/sqrt_pkg.sv
// Shared constants for the square-root core arbiter: FSM state codes, default widths, latency figures.
package sqrt_pkg;

  localparam int X_W_DEF = 8;
  localparam int R_W_DEF = 4;

  // One result bit of the core costs CORE_ITER_CYC cycles; the arbiter adds ARB_OVH_CYC around it.
  localparam int CORE_ITER_CYC = 6;
  localparam int ARB_OVH_CYC   = 6;

  typedef logic [2:0] arb_state_t;

  localparam arb_state_t ST_IDLE = 3'd0;
  localparam arb_state_t ST_LOAD = 3'd1;
  localparam arb_state_t ST_RUN  = 3'd2;
  localparam arb_state_t ST_WAIT = 3'd3;
  localparam arb_state_t ST_RESP = 3'd4;

endpackage

// File: rtl/sqrt_rr_arb.sv
// Round-robin selector: combinational pick of the first valid requester at/after the pointer,
// pointer advanced past the winner only when the grant is taken.
module sqrt_rr_arb
  import sqrt_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int IDW   = $clog2(N_REQ)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_REQ-1:0] valid_i,
  input  logic             en_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [IDW-1:0]   grant_id_o,
  output logic             any_o
);

  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] ptr_d;
  int             idx;

  always_comb begin
    any_o      = 1'b0;
    grant_id_o = '0;
    idx        = 0;
    for (int off = 0; off < N_REQ; off++) begin
      idx = int'(ptr_q) + off;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!any_o && valid_i[idx[IDW-1:0]]) begin
        any_o      = 1'b1;
        grant_id_o = idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    grant_o = '0;
    ptr_d   = ptr_q;
    if (en_i && any_o) begin
      grant_o[grant_id_o] = 1'b1;
      ptr_d = (grant_id_o == IDW'(N_REQ - 1)) ? '0 : grant_id_o + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/sqrt_arbiter.sv
// Shares one sequential square-root core between N_REQ requesters, one operation in flight.
// Optional watchdog abort enabled by defining SQRT_ARB_WDT_EN.
module sqrt_arbiter
  import sqrt_pkg::*;
#(
  parameter  int N_REQ   = 4,
  parameter  int X_W     = X_W_DEF,
  parameter  int R_W     = R_W_DEF,
  parameter  int WDT_CYC = 128,
  localparam int IDW     = $clog2(N_REQ)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [N_REQ-1:0]   req_valid_i,
  input  logic [N_REQ*X_W-1:0] req_x_i,
  output logic [N_REQ-1:0]   req_ready_o,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [IDW-1:0]     rsp_id_o,
  output logic [R_W-1:0]     rsp_r_o,
  output logic               rsp_err_o,
  output logic               core_enb_o,
  output logic [X_W-1:0]     core_x_o,
  input  logic               core_busy_i,
  input  logic [R_W-1:0]     core_r_i,
  output logic               busy_o
);

  if (N_REQ < 2 || N_REQ > 8 || 2 * R_W != X_W || WDT_CYC < 2) begin : g_cfg_err
    $error("sqrt_arbiter: unsupported parameter set");
  end

  logic [X_W-1:0] x_arr [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign x_arr[gi] = req_x_i[gi*X_W +: X_W];
  end

  arb_state_t     state_q, state_d;
  logic [X_W-1:0] x_q, x_d;
  logic [IDW-1:0] id_q, id_d;
  logic [R_W-1:0] r_q, r_d;
  logic           grant_en;
  logic           any_valid;
  logic [IDW-1:0] grant_id;

`ifdef SQRT_ARB_WDT_EN
  localparam int WDT_W = $clog2(WDT_CYC + 1);
  logic             err_q, err_d;
  logic [WDT_W-1:0] wdt_q, wdt_d;
`endif

  sqrt_rr_arb #(.N_REQ(N_REQ)) u_rr (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .valid_i    (req_valid_i),
    .en_i       (grant_en),
    .grant_o    (req_ready_o),
    .grant_id_o (grant_id),
    .any_o      (any_valid)
  );

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    id_d     = id_q;
    r_d      = r_q;
    grant_en = 1'b0;
`ifdef SQRT_ARB_WDT_EN
    err_d    = err_q;
    wdt_d    = wdt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        grant_en = !rst_i;
        if (any_valid) begin
          x_d     = x_arr[grant_id];
          id_d    = grant_id;
          state_d = ST_LOAD;
`ifdef SQRT_ARB_WDT_EN
          err_d   = 1'b0;
`endif
        end
      end
      // Enable held low for a cycle so the core restarts from IDLE with the new operand.
      ST_LOAD: begin
        state_d = ST_RUN;
`ifdef SQRT_ARB_WDT_EN
        wdt_d   = '0;
`endif
      end
      ST_RUN:  if (core_busy_i) state_d = ST_WAIT;
      ST_WAIT: begin
        if (!core_busy_i) begin
          r_d     = core_r_i;
          state_d = ST_RESP;
        end
      end
      ST_RESP: if (rsp_ready_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
`ifdef SQRT_ARB_WDT_EN
    if ((state_q == ST_RUN || state_q == ST_WAIT) && state_d != ST_RESP) begin
      if (wdt_q == WDT_W'(WDT_CYC - 1)) begin
        state_d = ST_RESP;
        r_d     = '0;
        err_d   = 1'b1;
      end else begin
        wdt_d = wdt_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      id_q    <= '0;
      r_q     <= '0;
`ifdef SQRT_ARB_WDT_EN
      err_q   <= 1'b0;
      wdt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      id_q    <= id_d;
      r_q     <= r_d;
`ifdef SQRT_ARB_WDT_EN
      err_q   <= err_d;
      wdt_q   <= wdt_d;
`endif
    end
  end

  assign core_enb_o  = (state_q == ST_RUN) || (state_q == ST_WAIT);
  assign core_x_o    = x_q;
  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_id_o    = id_q;
  assign rsp_r_o     = r_q;
  assign busy_o      = (state_q != ST_IDLE);
`ifdef SQRT_ARB_WDT_EN
  assign rsp_err_o   = err_q;
`else
  assign rsp_err_o   = 1'b0;
`endif

endmodule
